// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbitration types and one-hot helpers
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic logic is_onehot(input logic [NUM_REQ-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // OR-reduces the indices of set bits; exact only for one-hot inputs.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_hold_ctrl_hold_timer.sv
// rtl/grant_hold_ctrl_hold_timer.sv - saturating hold counter with clear/inc/expired
module hold_timer #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LAST so the count can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/grant_hold_ctrl.sv
// rtl/grant_hold_ctrl.sv - held grant register with hold timer, dead cycle and timeout penalty
module grant_hold_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] pri_in,
  output logic [NUM_REQ-1:0] req_fwd,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout,
  output logic               pri_err
);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic               r_gnt_valid;
  logic               r_timeout;
  logic               r_pri_err;
  logic [NUM_REQ-1:0] r_penalty;

  logic w_issue;
  logic w_hold;
  logic w_expired;
  logic w_owner_req;

  assign w_owner_req = req[r_gnt_id];
  assign w_issue     = (r_state == IDLE) && enable && is_onehot(pri_in);
  // Counter advances only on cycles where the grant is actually kept.
  assign w_hold      = (r_state == GRANT) && enable && w_owner_req && !w_expired;

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_issue),
    .i_inc     (w_hold),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_pri_err   <= 1'b0;
      r_penalty   <= '0;
    end else begin
      r_timeout <= 1'b0;
      r_pri_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req == '0) r_penalty <= '0;
          if (enable) begin
            if (is_onehot(pri_in)) begin
              r_gnt       <= pri_in;
              r_gnt_id    <= onehot_to_idx(pri_in);
              r_gnt_valid <= 1'b1;
              r_penalty   <= '0;
              r_state     <= GRANT;
            end else if (pri_in != '0) begin
              r_pri_err <= 1'b1;
            end
          end
        end
        GRANT: begin
          // Release paths are checked before expiry so they never set a penalty.
          if (!enable || !w_owner_req) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_state     <= GAP;
          end else if (w_expired) begin
            r_timeout   <= 1'b1;
            r_penalty   <= r_gnt;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_state     <= GAP;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_fwd   = req & ~r_penalty;
  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;
  assign pri_err   = r_pri_err;

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// tb/tb_grant_hold_ctrl.sv - self-checking bench with behavioural grant model
module tb_grant_hold_ctrl;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [3:0] pri_in;
  logic [3:0] req_fwd;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       pri_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner index (-1 = none), visible grant cycles, dead-cycle flag.
  int         m_owner = -1;
  int         m_held  = 0;
  bit         m_gap   = 0;
  logic [3:0] m_mask  = '0;
  bit         m_to    = 0;
  bit         m_err   = 0;

  grant_hold_ctrl #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .pri_in    (pri_in),
    .req_fwd   (req_fwd),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .pri_err   (pri_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  // Model update and per-cycle comparison, 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic       s_rst, s_en;
    logic [3:0] s_req, s_pri;
    logic [3:0] e_gnt;
    logic [1:0] e_id;
    s_rst = reset; s_en = enable; s_req = req; s_pri = pri_in;
    m_to = 0; m_err = 0;
    if (!s_rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_mask = '0;
    end else if (m_owner >= 0) begin
      if (!s_en || !s_req[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_held == MAX_HOLD) begin
        m_mask = 4'(1 << m_owner); m_to = 1; m_owner = -1; m_gap = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      if (s_req == 4'b0000) m_mask = '0;
      if (s_en) begin
        if ($countones(s_pri) == 1) begin
          for (int i = 0; i < 4; i++) if (s_pri[i]) m_owner = i;
          m_held = 1; m_mask = '0;
        end else if (s_pri != 4'b0000) begin
          m_err = 1;
        end
      end
    end
    #1;
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    check("model_outputs", {7'd0, gnt, gnt_id, gnt_valid, timeout, pri_err},
          {7'd0, e_gnt, e_id, (m_owner >= 0), m_to, m_err});
    check("model_req_fwd", {12'd0, req_fwd}, {12'd0, req & ~m_mask});
  end

  initial begin
    int  cnt;
    bit  seen;
    reset = 1'b0; enable = 1'b0; req = 4'b1111; pri_in = 4'b0000;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("reset_gnt", {12'd0, gnt}, 16'h0000);
    check("reset_req_fwd", {12'd0, req_fwd}, 16'h000f);
    reset = 1'b1;
    @(negedge clk);
    check("idle_valid", {15'd0, gnt_valid}, 16'h0000);
    check("idle_req_fwd", {12'd0, req_fwd}, 16'h000f);

    // Basic grant and release
    enable = 1'b1; req = 4'b0100; pri_in = 4'b0100;
    @(negedge clk);
    check("basic_gnt", {12'd0, gnt}, 16'h0004);
    check("basic_id", {14'd0, gnt_id}, 16'h0002);
    req = 4'b0000; pri_in = 4'b0000;
    @(negedge clk);
    check("basic_release", {12'd0, gnt}, 16'h0000);
    @(negedge clk);

    // Hold timeout and penalty
    req = 4'b0011; pri_in = 4'b0001;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      pri_in = 4'b0000;
      if (gnt == 4'b0001) cnt++;
      if (timeout) seen = 1;
    end
    check("timeout_seen", {15'd0, seen}, 16'h0001);
    check("hold_cycles", 16'(cnt), 16'(MAX_HOLD));
    check("penalty_fwd", {12'd0, req_fwd}, 16'h0002);
    pri_in = 4'b0010;
    repeat (2) @(negedge clk);
    check("next_owner", {12'd0, gnt}, 16'h0002);
    check("penalty_clear", {12'd0, req_fwd}, 16'h0003);
    req = 4'b0000; pri_in = 4'b0000;
    repeat (2) @(negedge clk);

    // Enable drop in the 5th grant cycle
    req = 4'b0100; pri_in = 4'b0100;
    @(negedge clk);
    pri_in = 4'b0000;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_gnt", {12'd0, gnt}, 16'h0000);
    check("en_drop_timeout", {15'd0, timeout}, 16'h0000);
    enable = 1'b1; req = 4'b0000;
    repeat (2) @(negedge clk);

    // Reset mid-grant
    req = 4'b1000; pri_in = 4'b1000;
    @(negedge clk);
    pri_in = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_out", {9'd0, gnt, gnt_id, gnt_valid}, 16'h0000);
    reset = 1'b1; req = 4'b0000;
    @(negedge clk);

    // Multi-bit priority input
    req = 4'b0110; pri_in = 4'b0110;
    @(negedge clk);
    check("pri_err_pulse", {15'd0, pri_err}, 16'h0001);
    check("pri_err_gnt", {12'd0, gnt}, 16'h0000);
    pri_in = 4'b0000;
    @(negedge clk);
    check("pri_err_clear", {15'd0, pri_err}, 16'h0000);

    // Owner drops request on its last hold cycle
    req = 4'b0011; pri_in = 4'b0001;
    @(negedge clk);
    pri_in = 4'b0000;
    repeat (MAX_HOLD - 1) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    check("simul_gnt", {12'd0, gnt}, 16'h0000);
    check("simul_timeout", {15'd0, timeout}, 16'h0000);
    check("simul_no_penalty", {12'd0, req_fwd}, 16'h0002);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 30) != 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 19) == 0) req[b] = ~req[b];
      end
      case ($urandom_range(0, 15))
        0:       pri_in = 4'($urandom_range(0, 15));
        1:       pri_in = 4'b0000;
        default: pri_in = lowest_bit(req & ~m_mask);
      endcase
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_hold_ctrl.md
Name: grant_hold_ctrl

Overview:
- Sequential stage directly downstream of the 4-way fixed-priority logic.
- Registers the one-hot priority decision as a held grant and keeps it until the owner drops its request, a hold timer expires, or enable falls.
- Inserts a one-cycle dead cycle between owners.
- Feeds a masked request vector back to the priority stage, so an owner that timed out loses the next arbitration round.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 to match the priority stage.
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership (legal range 2..255).
- CNT_W, 8, hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- enable  input  1  arbitration enable; same signal that drives the priority stage.
- req  input  4  raw request vector from requesters.
- pri_in  input  4  one-hot (or zero) decision from the priority stage.
- req_fwd  output  4  req & ~penalty_mask, combinational; drives the priority stage input.
- gnt  output  4  registered one-hot grant.
- gnt_id  output  2  binary index of the gnt bit; 0 when gnt==0.
- gnt_valid  output  1  high when gnt != 0.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold timer.
- pri_err  output  1  one-cycle pulse when pri_in has more than one bit set while sampled.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; gnt=0, gnt_id=0, gnt_valid=0, timeout=0, pri_err=0.
  - hold_cnt=0, penalty_mask=0.
  - Reset has priority over every other event, including mid-grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Sample pri_in when enable==1.
  - pri_in one-hot: gnt<=pri_in, hold_cnt<=0, penalty_mask<=0, go to GRANT.
  - pri_in==0: stay in IDLE.
  - pri_in with more than one bit set: pri_err<=1 for one cycle, no grant, stay in IDLE.
  - enable==0: stay in IDLE, no pri_err.
- GRANT (owner = gnt_id). Checks are evaluated in this order:
  - enable==0: go to GAP.
  - req[owner]==0: go to GAP.
  - hold_cnt==MAX_HOLD-1: timeout<=1, penalty_mask<=gnt, go to GAP.
  - Otherwise hold_cnt<=hold_cnt+1 and gnt is held.
  - pri_in is ignored in GRANT.
- GAP: gnt<=0 for exactly one cycle (asserted on the GAP entry edge), then go to IDLE.
- Latency:
  - pri_in sampled at edge N drives gnt/gnt_valid/gnt_id after edge N.
  - An owner's req drop at edge N clears gnt after edge N.
  - The next grant can appear after edge N+2 at the earliest.
- Hold length: a continuously requesting owner holds gnt for exactly MAX_HOLD cycles.
- penalty_mask:
  - Set only on timeout.
  - Cleared when the next grant is issued.
  - Cleared when all req bits are 0 in IDLE.
  - This prevents a permanent lockout when only the penalised requester is active.
- gnt_id and gnt_valid are registered alongside gnt, never decoded combinationally from a stale value.
- hold_cnt saturates and does not wrap; the counter must never exceed MAX_HOLD-1.
- Simultaneous events:
  - timeout and req drop in the same cycle count as a release: no timeout pulse, no penalty.
  - enable falling and timeout in the same cycle: the enable path wins, no penalty.

Decomposition:
- Shared package arb_pkg holds:
  - NUM_REQ.
  - State enum typedef (IDLE, GRANT, GAP).
  - A onehot-check function.
  - A onehot-to-index function; the priority stage and this block share it.
- One natural sub-module: hold_timer, the saturating counter with clear/inc/expired.
- The FSM, grant registers and mask logic remain in the top module.

Test Plan:
- Reset/idle check: reset=0 for 2 cycles with req=4'b1111, then reset=1 and enable=0 -> gnt=0, gnt_valid=0, and req_fwd=4'b1111 throughout.
- Basic grant and release: enable=1, req=4'b0100, pri_in=4'b0100 -> gnt=4'b0100 and gnt_id=2 one cycle later; drop req[2] -> gnt=0 next cycle, one GAP cycle, back to IDLE.
- Hold timeout with MAX_HOLD=16: req=4'b0011 held, pri_in=4'b0001 -> gnt=4'b0001 for exactly 16 cycles, then timeout pulse, req_fwd=4'b0010. With pri_in=4'b0010 after GAP -> gnt=4'b0010 and penalty_mask cleared.
- Mid-grant disruption: enable=0 in the 5th grant cycle -> gnt=0 next cycle with no timeout. Separately, reset=0 mid-grant -> all outputs 0 after that edge.
- Bad priority input: pri_in=4'b0110 in IDLE with enable=1 -> pri_err one-cycle pulse, gnt stays 0.
- Simultaneous drop and expiry: owner drops req on the cycle hold_cnt==15 -> gnt clears, timeout=0, penalty_mask=0.
